// File: rtl/lfsr_8bit_checker.sv
// Receive-side checker for the 8-bit XNOR LFSR stream: self-seeds, locks after LOCK_CNT
// correct predictions, counts mismatches while locked. All outputs registered (1 cycle); no backpressure.
module lfsr_8bit_checker #(
   parameter int unsigned LOCK_CNT   = 4,
   parameter int unsigned UNLOCK_CNT = 3,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   input  logic                 valid_i,
   input  logic [7:0]           data_i,
   output logic                 locked_o,
   output logic                 err_o,
   output logic [CNT_WIDTH-1:0] err_cnt_o,
   output logic [7:0]           expected_o
);

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_LOCKING  = 2'd1,
      ST_LOCKED   = 2'd2
   } state_e;

   localparam logic [3:0] LOCK_LAST   = 4'(LOCK_CNT - 1);
   localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_CNT - 1);
   localparam logic [7:0] LOCKUP_VAL  = 8'hFF;

   function automatic logic [7:0] lfsr_next(input logic [7:0] x);
      return {x[6:0], ~(x[7] ^ x[3] ^ x[2] ^ x[1])};
   endfunction

   state_e               state_q, state_d;
   logic [7:0]           expected_q, expected_d;
   logic [3:0]           match_cnt_q, match_cnt_d;
   logic [3:0]           miss_cnt_q, miss_cnt_d;
   logic                 err_q, err_d;
   logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
   logic                 hit;

   assign hit = (data_i == expected_q);

   always_comb begin
      state_d     = state_q;
      expected_d  = expected_q;
      match_cnt_d = match_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      err_d       = 1'b0;
      err_cnt_d   = err_cnt_q;

      if (flush_i) begin
         state_d     = ST_UNLOCKED;
         expected_d  = 8'h00;
         match_cnt_d = '0;
         miss_cnt_d  = '0;
         err_cnt_d   = '0;
      end else if (valid_i) begin
         unique case (state_q)
            ST_UNLOCKED: begin
               if (data_i != LOCKUP_VAL) begin
                  state_d     = ST_LOCKING;
                  expected_d  = lfsr_next(data_i);
                  match_cnt_d = '0;
               end
            end
            ST_LOCKING: begin
               // A mismatch simply reseeds from the current beat.
               expected_d = lfsr_next(data_i);
               if (hit) begin
                  if (match_cnt_q == LOCK_LAST) begin
                     state_d    = ST_LOCKED;
                     miss_cnt_d = '0;
                  end else begin
                     match_cnt_d = match_cnt_q + 4'd1;
                  end
               end else if (data_i == LOCKUP_VAL) begin
                  state_d = ST_UNLOCKED;
               end else begin
                  match_cnt_d = '0;
               end
            end
            ST_LOCKED: begin
               // Free-run the prediction; never resynchronise while locked.
               expected_d = lfsr_next(expected_q);
               if (hit) begin
                  miss_cnt_d = '0;
               end else begin
                  err_d = 1'b1;
                  if (err_cnt_q != '1) begin
                     err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
                  end
                  if (miss_cnt_q == UNLOCK_LAST) begin
                     state_d    = ST_UNLOCKED;
                     miss_cnt_d = '0;
                  end else begin
                     miss_cnt_d = miss_cnt_q + 4'd1;
                  end
               end
            end
            default: begin
               state_d = ST_UNLOCKED;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_UNLOCKED;
         expected_q  <= 8'h00;
         match_cnt_q <= '0;
         miss_cnt_q  <= '0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         expected_q  <= expected_d;
         match_cnt_q <= match_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         err_q       <= err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign locked_o   = (state_q == ST_LOCKED);
   assign err_o      = err_q;
   assign err_cnt_o  = err_cnt_q;
   assign expected_o = expected_q;

endmodule

// File: tb/tb_lfsr_8bit_checker.sv
// Bench for lfsr_8bit_checker: default instance plus a CNT_WIDTH=2/UNLOCK_CNT=15 instance,
// both scored per beat against a behavioural model through an expected-result queue.
module tb_lfsr_8bit_checker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        vld = 1'b0;
   logic [7:0]  dat = 8'h00;
   logic        lk0, er0, lk1, er1;
   logic [15:0] cnt0;
   logic [1:0]  cnt1;
   logic [7:0]  ex0, ex1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lfsr_8bit_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_WIDTH(16)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(vld), .data_i(dat),
      .locked_o(lk0), .err_o(er0), .err_cnt_o(cnt0), .expected_o(ex0));

   lfsr_8bit_checker #(.LOCK_CNT(4), .UNLOCK_CNT(15), .CNT_WIDTH(2)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(vld), .data_i(dat),
      .locked_o(lk1), .err_o(er1), .err_cnt_o(cnt1), .expected_o(ex1));

   typedef struct {
      int         st;   // 0 unlocked, 1 locking, 2 locked
      logic [7:0] ex;
      int         mc;
      int         mi;
      logic       er;
      int         cnt;
   } mdl_t;

   typedef struct {
      logic       lk0, er0, lk1, er1;
      int         c0, c1;
      logic [7:0] ex0, ex1;
   } exp_t;

   mdl_t m0, m1;
   exp_t sb[$];

   function automatic logic [7:0] nxt(input logic [7:0] x);
      logic fb;
      fb = ~(x[7] ^ x[3] ^ x[2] ^ x[1]);
      return {x[6:0], fb};
   endfunction

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.st = 0; m.ex = 8'h00; m.mc = 0; m.mi = 0; m.er = 1'b0; m.cnt = 0;
      return m;
   endfunction

   function automatic mdl_t mstep(input mdl_t mi_in, input logic f, input logic v,
                                  input logic [7:0] d, input int lkn, input int uln,
                                  input int cmax);
      mdl_t m;
      m = mi_in;
      m.er = 1'b0;
      if (f) begin
         m = mdl_reset();
      end else if (v) begin
         if (m.st == 0) begin
            if (d != 8'hFF) begin
               m.st = 1; m.ex = nxt(d); m.mc = 0;
            end
         end else if (m.st == 1) begin
            if (d == m.ex) begin
               if (m.mc + 1 == lkn) begin
                  m.st = 2; m.mi = 0;
               end else begin
                  m.mc++;
               end
            end else if (d == 8'hFF) begin
               m.st = 0;
            end else begin
               m.mc = 0;
            end
            m.ex = nxt(d);
         end else begin
            if (d == m.ex) begin
               m.mi = 0;
            end else begin
               m.er = 1'b1;
               if (m.cnt < cmax) m.cnt++;
               if (m.mi + 1 == uln) begin
                  m.st = 0; m.mi = 0;
               end else begin
                  m.mi++;
               end
            end
            m.ex = nxt(m.ex);
         end
      end
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Drive one cycle of stimulus, push the model's prediction, then score the DUT output.
   task automatic beat(input logic f, input logic v, input logic [7:0] d);
      exp_t e;
      flush = f; vld = v; dat = d;
      m0 = mstep(m0, f, v, d, 4, 3, 65535);
      m1 = mstep(m1, f, v, d, 4, 15, 3);
      e.lk0 = (m0.st == 2); e.er0 = m0.er; e.c0 = m0.cnt; e.ex0 = m0.ex;
      e.lk1 = (m1.st == 2); e.er1 = m1.er; e.c1 = m1.cnt; e.ex1 = m1.ex;
      sb.push_back(e);
      @(posedge clk);
      #1;
      flush = 1'b0; vld = 1'b0;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk("lk0", 32'(lk0), 32'(e.lk0));
         chk("er0", 32'(er0), 32'(e.er0));
         chk("cnt0", 32'(cnt0), 32'(e.c0));
         chk("ex0", 32'(ex0), 32'(e.ex0));
         chk("lk1", 32'(lk1), 32'(e.lk1));
         chk("er1", 32'(er1), 32'(e.er1));
         chk("cnt1", 32'(cnt1), 32'(e.c1));
         chk("ex1", 32'(ex1), 32'(e.ex1));
      end
   endtask

   task automatic clean_run(input logic [7:0] start, input int n);
      logic [7:0] x;
      x = start;
      for (int i = 0; i < n; i++) begin
         beat(1'b0, 1'b1, x);
         x = nxt(x);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] x;
      m0 = mdl_reset();
      m1 = mdl_reset();
      #3;
      chk("rst_lk", 32'(lk0), 32'd0);
      chk("rst_err", 32'(er0), 32'd0);
      chk("rst_cnt", 32'(cnt0), 32'd0);
      chk("rst_exp", 32'(ex0), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Clean lock: not locked through the 5th beat, locked after.
      beat(1'b0, 1'b1, 8'h00);
      beat(1'b0, 1'b1, 8'h01);
      beat(1'b0, 1'b1, 8'h03);
      beat(1'b0, 1'b1, 8'h06);
      chk("lock_early", 32'(lk0), 32'd0);
      beat(1'b0, 1'b1, 8'h0D);
      chk("lock_up", 32'(lk0), 32'd1);
      chk("lock_exp", 32'(ex0), 32'h1B);
      chk("lock_cnt", 32'(cnt0), 32'd0);

      // Idle cycle holds state.
      beat(1'b0, 1'b0, 8'h5A);
      chk("idle_exp", 32'(ex0), 32'h1B);

      // Single error.
      beat(1'b0, 1'b1, 8'h1B);
      beat(1'b0, 1'b1, 8'h00);
      chk("serr_pulse", 32'(er0), 32'd1);
      beat(1'b0, 1'b1, 8'h6F);
      chk("serr_clr", 32'(er0), 32'd0);
      chk("serr_cnt", 32'(cnt0), 32'd1);
      chk("serr_lk", 32'(lk0), 32'd1);
      chk("serr_exp", 32'(ex0), 32'hDE);

      // Three consecutive misses unlock.
      for (int i = 0; i < 3; i++) begin
         chk("unl_still_lk", 32'(lk0), 32'd1);
         beat(1'b0, 1'b1, 8'hAA);
         chk("unl_pulse", 32'(er0), 32'd1);
      end
      chk("unl_cnt", 32'(cnt0), 32'd4);
      chk("unl_lk", 32'(lk0), 32'd0);
      clean_run(8'h00, 5);
      chk("relock", 32'(lk0), 32'd1);

      // Lock-up value in UNLOCKED, then reseed in LOCKING.
      beat(1'b1, 1'b0, 8'h00);
      beat(1'b0, 1'b1, 8'hFF);
      beat(1'b0, 1'b1, 8'hFF);
      chk("ff_exp", 32'(ex0), 32'h00);
      chk("ff_lk", 32'(lk0), 32'd0);
      beat(1'b0, 1'b1, 8'h00);
      beat(1'b0, 1'b1, 8'h01);
      beat(1'b0, 1'b1, 8'h03);
      beat(1'b0, 1'b1, 8'h55);
      chk("reseed_exp", 32'(ex0), 32'(nxt(8'h55)));
      x = nxt(8'h55);
      for (int i = 0; i < 3; i++) begin
         beat(1'b0, 1'b1, x);
         x = nxt(x);
      end
      chk("reseed_not_lk", 32'(lk0), 32'd0);
      beat(1'b0, 1'b1, x);
      chk("reseed_lk", 32'(lk0), 32'd1);
      chk("reseed_cnt", 32'(cnt0), 32'd0);

      // Saturation on the 2-bit counter instance.
      beat(1'b1, 1'b0, 8'h00);
      clean_run(8'h00, 5);
      chk("sat_lk", 32'(lk1), 32'd1);
      for (int i = 0; i < 5; i++) begin
         beat(1'b0, 1'b1, 8'hFF);
         chk("sat_pulse", 32'(er1), 32'd1);
         chk("sat_cnt", 32'(cnt1), (i < 3) ? 32'(i + 1) : 32'd3);
      end

      // Flush beats a coincident valid beat.
      beat(1'b1, 1'b0, 8'h00);
      clean_run(8'h00, 5);
      beat(1'b0, 1'b1, 8'hAA);
      beat(1'b0, 1'b1, 8'hAA);
      chk("fl_pre_cnt", 32'(cnt0), 32'd2);
      chk("fl_pre_lk", 32'(lk0), 32'd1);
      beat(1'b1, 1'b1, 8'h37);
      chk("fl_lk", 32'(lk0), 32'd0);
      chk("fl_cnt", 32'(cnt0), 32'd0);
      chk("fl_exp", 32'(ex0), 32'h00);
      chk("fl_err", 32'(er0), 32'd0);

      // Reset mid-LOCKING clears immediately.
      beat(1'b0, 1'b1, 8'h00);
      beat(1'b0, 1'b1, 8'h01);
      #2;
      rst_n = 1'b0;
      #1;
      m0 = mdl_reset();
      m1 = mdl_reset();
      chk("ar_lk", 32'(lk0), 32'd0);
      chk("ar_err", 32'(er0), 32'd0);
      chk("ar_cnt", 32'(cnt0), 32'd0);
      chk("ar_exp", 32'(ex0), 32'h00);
      chk("ar_exp1", 32'(ex1), 32'h00);
      @(posedge clk); #1;
      rst_n = 1'b1;
      clean_run(8'h37, 4);
      chk("ar_not_lk", 32'(lk0), 32'd0);
      clean_run(nxt(nxt(nxt(nxt(8'h37)))), 1);
      chk("ar_relock", 32'(lk0), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lfsr_8bit_checker.md
# lfsr_8bit_checker

Receive-side checker for the 8-bit XNOR LFSR sequence used by our pseudo-random way-selection and test-pattern generators. It consumes a stream of 8-bit LFSR state samples and self-synchronises by seeding from the stream itself. It then predicts each following sample, declares lock after a run of correct predictions, and counts mismatches while locked. It sits at the far end of any link or buffer fed by the 8-bit LFSR generator and serves as a built-in integrity monitor.

## Interface
- `LOCK_CNT`, default 4: consecutive matching beats after the seed beat required to enter LOCKED; legal range 1..15.
- `UNLOCK_CNT`, default 3: consecutive mismatching beats in LOCKED that force UNLOCKED; legal range 1..15.
- `CNT_WIDTH`, default 16: width of the error counter; must be at least 1.
- `clk_i`  in  1  clock. There is one clock; the block is fully synchronous to `clk_i`.
- `rst_ni`  in  1  reset. Asynchronous, active-low.
- `flush_i`  in  1  synchronous restart. Returns to UNLOCKED and clears all counters.
- `valid_i`  in  1  `data_i` carries a sample this cycle. There is no backpressure: every valid beat is consumed.
- `data_i`  in  8  received LFSR state sample.
- `locked_o`  out  1  registered; high while in LOCKED.
- `err_o`  out  1  registered one-cycle pulse for a mismatch detected in LOCKED.
- `err_cnt_o`  out  `CNT_WIDTH`  saturating count of mismatches detected in LOCKED.
- `expected_o`  out  8  prediction register: the value the next valid beat is compared against.

## Operation
- Next-state function: next(x) = {x[6:0], ~(x[7]^x[3]^x[2]^x[1])}. The reference sequence from 0x00 is 00, 01, 03, 06, 0D, 1B, 37, 6F, DE.
- 0xFF is the lock-up value of this LFSR and is never used as a seed.
- States and transitions; the tests below apply only on cycles with `valid_i`=1 and `flush_i`=0:
  - UNLOCKED:
    - `data_i`≠0xFF: set `expected` to next(`data_i`), set `match_cnt` to 0, go to LOCKING.
    - `data_i`=0xFF: stay in UNLOCKED; `expected` is unchanged.
  - LOCKING:
    - `data_i`==`expected` and `match_cnt`+1==`LOCK_CNT`: go to LOCKED with `miss_cnt`=0.
    - `data_i`==`expected` otherwise: increment `match_cnt`.
    - Mismatch: reseed from this beat using the UNLOCKED rules. A mismatching 0xFF goes to UNLOCKED.
    - `expected` becomes next(`data_i`) on every valid beat in LOCKING.
  - LOCKED:
    - `expected` always becomes next(`expected`), regardless of the received data. The stream is never resynchronised while locked.
    - Match: clear `miss_cnt`.
    - Mismatch: pulse `err_o`, increment `err_cnt_o` (saturates at all-ones, never wraps) and increment `miss_cnt`.
    - If `miss_cnt`+1==`UNLOCK_CNT`, go to UNLOCKED. The mismatch that causes the unlock is still counted and pulsed.
- Mismatches seen in UNLOCKED or LOCKING never touch `err_o` or `err_cnt_o`.
- Cycles with `valid_i`=0 hold all state; `err_o` is 0 on those cycles.
- `flush_i` has priority over `valid_i`; a beat presented in the same cycle as `flush_i` is dropped. `flush_i` sets:
  - state to UNLOCKED;
  - `match_cnt`, `miss_cnt` and `err_cnt_o` to 0;
  - `expected_o` to 0x00;
  - `err_o` to 0.
- `data_i` is ignored when `valid_i`=0.

## Timing
- Reset values: state UNLOCKED, `locked_o`=0, `err_o`=0, `err_cnt_o`=0, `expected_o`=0x00, internal counters 0.
- All outputs are registered. The compare is combinational on `data_i` against the `expected` register, and its effects appear the cycle after the beat.
- Lock latency: with back-to-back beats and `LOCK_CNT`=N, `locked_o` rises 1 cycle after beat N (beats numbered 0..N, beat 0 being the seed).
- `err_o` asserts the cycle after a mismatching locked beat. `err_cnt_o` updates in the same cycle as `err_o`.
- `locked_o` falls the cycle after the `UNLOCK_CNT`-th consecutive mismatch.
- Beats may arrive every cycle; there are no bubble or throughput restrictions.
- Asserting reset mid-stream clears everything immediately. Lock is reacquired only after a fresh seed beat plus `LOCK_CNT` matching beats.

## Test plan
- Clean lock: drive 00,01,03,06,0D back-to-back (defaults) -> `locked_o` 0 through the 5th beat's cycle, 1 the cycle after; `expected_o`=0x1B; `err_cnt_o`=0.
- Single error: after lock, send 1B,00,6F (00 replaces 37) -> one `err_o` pulse the cycle after 00; `err_cnt_o`=1; `locked_o` stays 1; `expected_o`=0xDE.
- Unlock: after lock, send 3 consecutive wrong beats -> 3 `err_o` pulses, `err_cnt_o`=3, `locked_o` falls after the 3rd; a subsequent clean 5-beat run relocks.
- Lock-up and reseed: in UNLOCKED send FF,FF -> stays UNLOCKED, `expected_o` unchanged. In LOCKING, send 01,03,55 then 55's successors -> reseeds on 55; locked only after 4 further matches; `err_cnt_o` stays 0.
- Saturation: `CNT_WIDTH`=2, locked, `UNLOCK_CNT`=15, send 5 mismatching beats -> `err_cnt_o` reads 1,2,3,3,3; `err_o` pulses all 5 times.
- Flush/reset priority: assert `flush_i` with `valid_i` while locked with `err_cnt_o`=2 -> next cycle `locked_o`=0, `err_cnt_o`=0, `expected_o`=0x00, beat ignored. Drop `rst_ni` mid-LOCKING -> all outputs at reset values immediately.
